// File: rtl/dfi_pkg.sv
// rtl/dfi_pkg.sv - DFI beat geometry and command decode shared by the PHY responder
package dfi_pkg;

    localparam int C_DFI_FREQ_RATIO = 2;
    localparam int C_DFI_DATA_WIDTH = 32;
    localparam int C_BEAT_WIDTH     = C_DFI_FREQ_RATIO * C_DFI_DATA_WIDTH;
    localparam int C_MASK_WIDTH     = C_BEAT_WIDTH / 8;

    typedef enum logic [1:0] {
        NOP,
        RD,
        WR,
        OTHER
    } dfi_cmd_e;

    function automatic dfi_cmd_e dfi_decode(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_n);
        if (cs_n) begin
            return NOP;
        end
        if (ras_n && !cas_n) begin
            return we_n ? RD : WR;
        end
        return OTHER;
    endfunction

endpackage

// File: rtl/dfi_delay_line.sv
// rtl/dfi_delay_line.sv - fixed-depth valid/data shift register; depth 0 is a wire
module dfi_delay_line #(
    parameter int C_DEPTH = 1,
    parameter int C_WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [C_WIDTH-1:0] data_i,
    output logic               valid_o,
    output logic [C_WIDTH-1:0] data_o
);

    generate
        if (C_DEPTH == 0) begin : g_bypass
            assign valid_o = valid_i;
            assign data_o  = data_i;
        end else begin : g_shift
            logic [C_DEPTH-1:0] valid_q;
            logic [C_WIDTH-1:0] data_q [C_DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= valid_i;
                    for (int i = 1; i < C_DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            // Payload is qualified by valid downstream, so it carries no reset
            always_ff @(posedge clk) begin
                data_q[0] <= data_i;
                for (int i = 1; i < C_DEPTH; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end

            assign valid_o = valid_q[C_DEPTH-1];
            assign data_o  = data_q[C_DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sfifo.sv
// rtl/sfifo.sv - small synchronous FIFO with fall-through head, full/empty flags
module sfifo #(
    parameter int C_ADDR_WIDTH = 2,
    parameter int C_DATA_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [C_DATA_WIDTH-1:0] push_data_i,
    input  logic                    pop_i,
    output logic [C_DATA_WIDTH-1:0] pop_data_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int C_DEPTH = 1 << C_ADDR_WIDTH;

    logic [C_DATA_WIDTH-1:0] mem_q [C_DEPTH];
    logic [C_ADDR_WIDTH-1:0] wptr_q;
    logic [C_ADDR_WIDTH-1:0] rptr_q;
    logic [C_ADDR_WIDTH:0]   count_q;
    logic                    do_push;
    logic                    do_pop;

    // Both flags come from the pre-update count, so a same-cycle push is invisible to pop
    assign full_o     = count_q[C_ADDR_WIDTH];
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_q + {{C_ADDR_WIDTH{1'b0}}, do_push}
                               - {{C_ADDR_WIDTH{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dfi_phy_responder.sv
// rtl/dfi_phy_responder.sv - loopback PHY: queues RD/WR indices, stores write beats, returns reads
module dfi_phy_responder
    import dfi_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 14,
    parameter int C_MEM_ADDR_WIDTH  = 6,
    parameter int C_CMDQ_ADDR_WIDTH = 2,
    parameter int C_TPHY_WRDATA     = 1,
    parameter int C_TPHY_RDLAT      = 4
) (
    input  logic                    core_clk,
    input  logic                    core_arstn,
    input  logic [C_ADDR_WIDTH-1:0] dfi_address,
    input  logic                    dfi_cs_n,
    input  logic                    dfi_ras_n,
    input  logic                    dfi_cas_n,
    input  logic                    dfi_we_n,
    input  logic                    dfi_wrdata_en,
    input  logic [C_BEAT_WIDTH-1:0] dfi_wrdata,
    input  logic [C_MASK_WIDTH-1:0] dfi_wrdata_mask,
    input  logic                    dfi_rddata_en,
    output logic [C_BEAT_WIDTH-1:0] dfi_rddata,
    output logic                    dfi_rddata_valid,
    output logic                    err_wr_orphan,
    output logic                    err_rd_orphan,
    output logic                    err_cmdq_ovf
);

    localparam int C_MEM_DEPTH = 1 << C_MEM_ADDR_WIDTH;
    localparam int C_WBUS      = C_BEAT_WIDTH + C_MASK_WIDTH;

    dfi_cmd_e                    cmd;
    logic [C_MEM_ADDR_WIDTH-1:0] cmd_idx;
    logic                        addr_unused;
    logic                        wq_full, wq_empty, rq_full, rq_empty;
    logic [C_MEM_ADDR_WIDTH-1:0] wq_idx, rq_idx;

    logic                        wr_stb;
    logic [C_WBUS-1:0]           wr_bus;
    logic [C_BEAT_WIDTH-1:0]     wr_data;
    logic [C_MASK_WIDTH-1:0]     wr_mask;
    logic [C_BEAT_WIDTH-1:0]     wr_merged;
    logic                        wr_commit;

    logic [C_BEAT_WIDTH-1:0]     mem_q [C_MEM_DEPTH];
    logic                        rd_en_q, rd_hit_q, rd_vld_q;
    logic [C_MEM_ADDR_WIDTH-1:0] rd_idx_q;
    logic [C_BEAT_WIDTH-1:0]     rd_data_q;
    logic                        rd_bypass;
    logic                        rd_out_vld;
    logic [C_BEAT_WIDTH-1:0]     rd_out_data;

    logic err_wr_q, err_wr_d, err_rd_q, err_rd_d, err_ovf_q, err_ovf_d;

    assign cmd         = dfi_decode(dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n);
    assign cmd_idx     = dfi_address[C_MEM_ADDR_WIDTH-1:0];
    assign addr_unused = ^dfi_address[C_ADDR_WIDTH-1:C_MEM_ADDR_WIDTH];

    sfifo #(.C_ADDR_WIDTH(C_CMDQ_ADDR_WIDTH), .C_DATA_WIDTH(C_MEM_ADDR_WIDTH)) u_wq (
        .clk(core_clk), .rst(core_arstn),
        .push_i(cmd == WR), .push_data_i(cmd_idx),
        .pop_i(wr_stb), .pop_data_o(wq_idx),
        .full_o(wq_full), .empty_o(wq_empty)
    );

    sfifo #(.C_ADDR_WIDTH(C_CMDQ_ADDR_WIDTH), .C_DATA_WIDTH(C_MEM_ADDR_WIDTH)) u_rq (
        .clk(core_clk), .rst(core_arstn),
        .push_i(cmd == RD), .push_data_i(cmd_idx),
        .pop_i(dfi_rddata_en), .pop_data_o(rq_idx),
        .full_o(rq_full), .empty_o(rq_empty)
    );

    dfi_delay_line #(.C_DEPTH(C_TPHY_WRDATA), .C_WIDTH(C_WBUS)) u_wr_dly (
        .clk(core_clk), .rst(core_arstn),
        .valid_i(dfi_wrdata_en), .data_i({dfi_wrdata, dfi_wrdata_mask}),
        .valid_o(wr_stb), .data_o(wr_bus)
    );

    assign wr_data   = wr_bus[C_WBUS-1:C_MASK_WIDTH];
    assign wr_mask   = wr_bus[C_MASK_WIDTH-1:0];
    assign wr_commit = wr_stb && !wq_empty;

    always_comb begin
        wr_merged = mem_q[wq_idx];
        for (int b = 0; b < C_MASK_WIDTH; b++) begin
            if (!wr_mask[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Same-index commit and fetch in one cycle: hand the freshly merged beat to the read
    assign rd_bypass = rd_hit_q && wr_commit && (wq_idx == rd_idx_q);

    always_ff @(posedge core_clk) begin
        if (wr_commit) begin
            mem_q[wq_idx] <= wr_merged;
        end
        if (rd_bypass) begin
            rd_data_q <= wr_merged;
        end else if (rd_hit_q) begin
            rd_data_q <= mem_q[rd_idx_q];
        end else begin
            rd_data_q <= '0;
        end
    end

    always_comb begin
        err_wr_d  = err_wr_q  || (wr_stb && wq_empty);
        err_rd_d  = err_rd_q  || (dfi_rddata_en && rq_empty);
        err_ovf_d = err_ovf_q || ((cmd == WR) && wq_full) || ((cmd == RD) && rq_full);
    end

    always_ff @(posedge core_clk or posedge core_arstn) begin
        if (core_arstn) begin
            rd_en_q   <= 1'b0;
            rd_hit_q  <= 1'b0;
            rd_idx_q  <= '0;
            rd_vld_q  <= 1'b0;
            err_wr_q  <= 1'b0;
            err_rd_q  <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            rd_en_q   <= dfi_rddata_en;
            rd_hit_q  <= dfi_rddata_en && !rq_empty;
            rd_idx_q  <= rq_idx;
            rd_vld_q  <= rd_en_q;
            err_wr_q  <= err_wr_d;
            err_rd_q  <= err_rd_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Enable sample and memory fetch consume two cycles of the read latency
    dfi_delay_line #(.C_DEPTH(C_TPHY_RDLAT - 2), .C_WIDTH(C_BEAT_WIDTH)) u_rd_dly (
        .clk(core_clk), .rst(core_arstn),
        .valid_i(rd_vld_q), .data_i(rd_data_q),
        .valid_o(rd_out_vld), .data_o(rd_out_data)
    );

    assign dfi_rddata_valid = rd_out_vld;
    assign dfi_rddata       = rd_out_vld ? rd_out_data : '0;
    assign err_wr_orphan    = err_wr_q;
    assign err_rd_orphan    = err_rd_q;
    assign err_cmdq_ovf     = err_ovf_q;

endmodule

// File: tb/tb_dfi_phy_responder.sv
// tb/tb_dfi_phy_responder.sv - scoreboard bench for the DFI loopback PHY responder
module tb_dfi_phy_responder;
    import dfi_pkg::*;

    localparam int RDLAT = 4;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] address = '0;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic        wrdata_en = 1'b0;
    logic [63:0] wrdata = '0;
    logic [7:0]  wmask = '0;
    logic        rddata_en = 1'b0;
    logic [63:0] rddata;
    logic        rddata_valid;
    logic        e_wr, e_rd, e_ovf;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    dfi_phy_responder dut (
        .core_clk(clk), .core_arstn(rst), .dfi_address(address),
        .dfi_cs_n(cs_n), .dfi_ras_n(ras_n), .dfi_cas_n(cas_n), .dfi_we_n(we_n),
        .dfi_wrdata_en(wrdata_en), .dfi_wrdata(wrdata), .dfi_wrdata_mask(wmask),
        .dfi_rddata_en(rddata_en), .dfi_rddata(rddata), .dfi_rddata_valid(rddata_valid),
        .err_wr_orphan(e_wr), .err_rd_orphan(e_rd), .err_cmdq_ovf(e_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input dfi_cmd_e c, input logic [5:0] idx, input logic wen,
                         input logic [63:0] wd, input logic [7:0] wm,
                         input logic ren, input logic [63:0] rexp);
        @(posedge clk);
        #1;
        case (c)
            WR:      {cs_n, ras_n, cas_n, we_n} = 4'b0100;
            RD:      {cs_n, ras_n, cas_n, we_n} = 4'b0101;
            OTHER:   {cs_n, ras_n, cas_n, we_n} = 4'b0011;
            default: {cs_n, ras_n, cas_n, we_n} = 4'b1111;
        endcase
        address   = {8'($urandom), idx};
        wrdata_en = wen;
        wrdata    = wd;
        wmask     = wm;
        rddata_en = ren;
        if (ren) sb.push_back('{data: rexp, cyc: cyc + RDLAT});
    endtask

    task automatic idle();
        drive(NOP, 6'd0, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (rddata_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", rddata_valid); end
        if (rddata !== 64'd0) begin errors++; $display("FAIL reset_rddata got=%h want=0", rddata); end
        if (e_wr !== 1'b0) begin errors++; $display("FAIL reset_err_wr got=%b want=0", e_wr); end
        if (e_rd !== 1'b0) begin errors++; $display("FAIL reset_err_rd got=%b want=0", e_rd); end
        if (e_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_ovf got=%b want=0", e_ovf); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loopback();
        drive(WR, 6'h05, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(NOP, 6'h00, 1'b1, 64'h0123456789ABCDEF, 8'h00, 1'b0, 64'd0);
        idle();
        drive(RD, 6'h05, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(NOP, 6'h00, 1'b0, 64'd0, 8'd0, 1'b1, 64'h0123456789ABCDEF);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            idle();
            @(negedge clk);
            if (rddata_valid) begin
                e = sb.pop_front();
                checks++;
                if (rddata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL loopback_read got=%h@%0d want=%h@%0d", rddata, cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL loopback_timeout pending=%0d want=0", sb.size()); sb.delete(); end
        idle();
        @(negedge clk);
        checks++;
        if (rddata_valid !== 1'b0 || rddata !== 64'd0) begin
            errors++;
            $display("FAIL loopback_one_cycle valid=%b data=%h want=0/0", rddata_valid, rddata);
        end
    endtask

    task automatic test_byte_mask();
        drive(WR, 6'h05, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(NOP, 6'h00, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b0, 64'd0);
        idle();
        drive(RD, 6'h05, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(NOP, 6'h00, 1'b0, 64'd0, 8'd0, 1'b1, 64'hFFFFFFFF89ABCDEF);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            idle();
            @(negedge clk);
            if (rddata_valid) begin
                e = sb.pop_front();
                checks++;
                if (rddata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL mask_read got=%h@%0d want=%h@%0d", rddata, cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL mask_timeout pending=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_orphan_read();
        checks++;
        if (e_rd !== 1'b0) begin errors++; $display("FAIL orphan_rd_pre got=%b want=0", e_rd); end
        drive(NOP, 6'h00, 1'b0, 64'd0, 8'd0, 1'b1, 64'd0);
        idle();
        @(negedge clk);
        checks++;
        if (e_rd !== 1'b1) begin errors++; $display("FAIL orphan_rd_flag got=%b want=1", e_rd); end
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            idle();
            @(negedge clk);
            if (rddata_valid) begin
                e = sb.pop_front();
                checks++;
                if (rddata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL orphan_read got=%h@%0d want=%h@%0d", rddata, cyc, e.data, e.cyc);
                end
            end
        end
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL orphan_timeout pending=%0d want=0", sb.size()); sb.delete(); end
        if (e_rd !== 1'b1) begin errors++; $display("FAIL orphan_rd_held got=%b want=1", e_rd); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) drive(WR, 6'(i), 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        checks++;
        if (e_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got=%b want=0", e_ovf); end
        idle();
        checks++;
        if (e_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", e_ovf); end
        for (int i = 1; i <= 5; i++)
            drive(NOP, 6'h00, 1'b1, 64'(i) * 64'h1111111111111111, 8'h00, 1'b0, 64'd0);
        checks++;
        if (e_wr !== 1'b0) begin errors++; $display("FAIL wr_orphan_pre got=%b want=0", e_wr); end
        repeat (3) idle();
        checks++;
        if (e_wr !== 1'b1) begin errors++; $display("FAIL wr_orphan_flag got=%b want=1", e_wr); end
    endtask

    task automatic test_back_to_back();
        drive(OTHER, 6'h06, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        for (int i = 1; i <= 4; i++) drive(RD, 6'(i), 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        for (int i = 1; i <= 4; i++)
            drive(NOP, 6'h00, 1'b0, 64'd0, 8'd0, 1'b1, 64'(i) * 64'h1111111111111111);
        for (int c = 0; c < 12 && sb.size() > 0; c++) begin
            idle();
            @(negedge clk);
            if (rddata_valid) begin
                e = sb.pop_front();
                checks++;
                if (rddata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL stream_read got=%h@%0d want=%h@%0d", rddata, cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL stream_timeout pending=%0d want=0", sb.size()); sb.delete(); end
        drive(RD, 6'h05, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(NOP, 6'h00, 1'b0, 64'd0, 8'd0, 1'b1, 64'hFFFFFFFF89ABCDEF);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            idle();
            @(negedge clk);
            if (rddata_valid) begin
                e = sb.pop_front();
                checks++;
                if (rddata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL dropped_idx5 got=%h@%0d want=%h@%0d", rddata, cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL idx5_timeout pending=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_collision();
        drive(WR, 6'h07, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(NOP, 6'h00, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'h00, 1'b0, 64'd0);
        drive(WR, 6'h07, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(RD, 6'h07, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(NOP, 6'h00, 1'b1, 64'h5555555555555555, 8'hF0, 1'b1, 64'hAAAAAAAA55555555);
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            idle();
            @(negedge clk);
            if (rddata_valid) begin
                e = sb.pop_front();
                checks++;
                if (rddata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL collision_read got=%h@%0d want=%h@%0d", rddata, cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL collision_timeout pending=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid_read();
        int seen;
        drive(RD, 6'h01, 1'b0, 64'd0, 8'd0, 1'b0, 64'd0);
        drive(NOP, 6'h00, 1'b0, 64'd0, 8'd0, 1'b1, 64'd0);
        idle();
        idle();
        rst = 1'b1;
        sb.delete();
        #1;
        checks += 2;
        if (rddata_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", rddata_valid); end
        if ({e_wr, e_rd, e_ovf} !== 3'b000) begin errors++; $display("FAIL midrst_errs got=%b want=000", {e_wr, e_rd, e_ovf}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            idle();
            @(negedge clk);
            if (rddata_valid) seen++;
        end
        checks += 2;
        if (seen != 0) begin errors++; $display("FAIL midrst_stale_valid got=%0d want=0", seen); end
        if ({e_wr, e_rd, e_ovf} !== 3'b000) begin errors++; $display("FAIL midrst_errs_after got=%b want=000", {e_wr, e_rd, e_ovf}); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_byte_mask();
        test_orphan_read();
        test_overflow();
        test_back_to_back();
        test_collision();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
